// File: rtl/cmp_outcome_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmp_outcome_tracker                                        |
// | Description : Counts EQ/GT/LT/error outcomes of a comparator over a       |
// |               window of WINDOW accepted samples. The totals are held on   |
// |               a valid/ready report interface until the consumer takes     |
// |               them. Optional macro STREAK_EN enables longest-run          |
// |               tracking on max_streak; otherwise max_streak is tied to 0.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cmp_outcome_tracker #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] max_streak,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  // Window length as seen by the 8-bit sample index.
  localparam logic [7:0] c_window = 8'(WINDOW);

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_idx;
  logic [7:0]       w_idx_inc;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_gt_cnt;
  logic [CNT_W-1:0] r_lt_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_accept;
  logic             w_drain;
  logic             w_is_eq;
  logic             w_is_gt;
  logic             w_is_lt;
  logic             w_is_err;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Handshake and one-hot classification of the incoming outcome.
  assign in_ready  = (r_state != S_REPORT);
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = (r_state == S_REPORT) & out_ready;
  assign w_idx_inc = r_idx + 8'd1;
  assign w_is_eq   = ({eq, gt, lt} == 3'b100);
  assign w_is_gt   = ({eq, gt, lt} == 3'b010);
  assign w_is_lt   = ({eq, gt, lt} == 3'b001);
  assign w_is_err  = ~(w_is_eq | w_is_gt | w_is_lt);

  // Outputs come straight from state/counter registers.
  assign out_valid = (r_state == S_REPORT);
  assign busy      = (r_state != S_IDLE);
  assign eq_cnt    = r_eq_cnt;
  assign gt_cnt    = r_gt_cnt;
  assign lt_cnt    = r_lt_cnt;
  assign err_cnt   = r_err_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: the accept that brings the index to WINDOW closes the window.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (w_idx_inc == c_window) ? S_REPORT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept && (w_idx_inc == c_window)) begin
          w_next_state = S_REPORT;
        end
      end
      S_REPORT: begin
        if (w_drain) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Sample index and outcome counters; cleared when the report is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_eq_cnt  <= '0;
      r_gt_cnt  <= '0;
      r_lt_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_drain) begin
      r_idx     <= '0;
      r_eq_cnt  <= '0;
      r_gt_cnt  <= '0;
      r_lt_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_accept) begin
      r_idx <= w_idx_inc;
      if (w_is_eq)  r_eq_cnt  <= sat_inc(r_eq_cnt);
      if (w_is_gt)  r_gt_cnt  <= sat_inc(r_gt_cnt);
      if (w_is_lt)  r_lt_cnt  <= sat_inc(r_lt_cnt);
      if (w_is_err) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

`ifdef STREAK_EN
  logic [1:0]       r_run_code;
  logic [1:0]       w_code;
  logic [CNT_W-1:0] r_run_len;
  logic [CNT_W-1:0] w_run_len_next;
  logic [CNT_W-1:0] r_max_streak;

  // Current run length: error breaks the run, a new outcome starts at 1.
  always_comb begin
    w_code         = 2'd0;
    w_run_len_next = r_run_len;
    if (w_is_gt) w_code = 2'd1;
    if (w_is_lt) w_code = 2'd2;
    if (w_is_err) begin
      w_run_len_next = '0;
    end else if ((r_run_len != '0) && (w_code == r_run_code)) begin
      w_run_len_next = sat_inc(r_run_len);
    end else begin
      w_run_len_next = CNT_W'(1);
    end
  end

  // Run tracker and window maximum; cleared together with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_code   <= 2'd0;
      r_run_len    <= '0;
      r_max_streak <= '0;
    end else if (w_drain) begin
      r_run_code   <= 2'd0;
      r_run_len    <= '0;
      r_max_streak <= '0;
    end else if (w_accept) begin
      r_run_code <= w_code;
      r_run_len  <= w_run_len_next;
      if (w_run_len_next > r_max_streak) begin
        r_max_streak <= w_run_len_next;
      end
    end
  end

  assign max_streak = r_max_streak;
`else
  assign max_streak = '0;
`endif

endmodule
`default_nettype wire
